cache_memory: RTL and testbench

- Single-clock, direct-mapped, write-back, write-allocate data cache between a CPU request port and a word-wide RAM bus.
- Covers the CPU-side request/acknowledge handshake, the tag/data arrays with per-line valid and dirty bits, and the line refill/writeback sequencer toward RAM.
- Processes one CPU request at a time.

---
 rtl/cache_memory.sv | 199 +++++++++++++++++++
 tb/tb_cache_memory.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_memory.sv
// rtl/cache_memory.sv - direct-mapped, write-back, write-allocate data cache with RAM refill/writeback sequencer
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_memory #(
    parameter int TAG_W    = 6,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = TAG_W + INDEX_W + OFFSET_W
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   CPU_ADDR,
    input  logic                CPU_RD,
    input  logic                CPU_WR,
    input  logic [DATA_W-1:0]   CPU_WDATA,
    input  logic [DATA_W/8-1:0] CPU_BVAL,
    output logic [DATA_W-1:0]   CPU_RDATA,
    output logic                CPU_ACK,
    output logic                RAM_REQ,
    output logic                RAM_RNW,
    output logic [ADDR_W-1:0]   RAM_ADDR,
    output logic [DATA_W-1:0]   RAM_WDATA,
    input  logic [DATA_W-1:0]   RAM_RDATA,
    input  logic                RAM_ACK
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]         HIT_CNT,
    output logic [15:0]         MISS_CNT
`endif
);
    localparam int LINES  = 1 << INDEX_W;
    localparam int WORD_W = OFFSET_W - 2;
    localparam int WORDS  = 1 << WORD_W;
    localparam int LANES  = DATA_W / 8;
    localparam logic [WORD_W-1:0] LAST_BEAT = '1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] WRITEBACK = 3'd2;
    localparam logic [2:0] REFILL    = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    logic [2:0]         state;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WORD_W-1:0]  req_word;
    logic [DATA_W-1:0]  req_wdata;
    logic [LANES-1:0]   req_bval;
    logic               req_wr;
    logic [WORD_W-1:0]  beat;
    logic [DATA_W-1:0]  rdata_q;
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [DATA_W-1:0]  data_mem [LINES * WORDS];

    logic [TAG_W-1:0]   victim_tag;
    logic               hit;
    logic               victim_dirty;
    logic               beat_done;
    logic [DATA_W-1:0]  cur_word;
    logic [DATA_W-1:0]  beat_word;
    logic [DATA_W-1:0]  merged_word;
    logic [DATA_W-1:0]  resp_word;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^CPU_ADDR[1:0];

    assign victim_tag   = tag_mem[req_index];
    assign hit          = valid[req_index] && (victim_tag == req_tag);
    assign victim_dirty = valid[req_index] && dirty[req_index];
    assign beat_done    = RAM_REQ && RAM_ACK;
    assign cur_word     = data_mem[{req_index, req_word}];
    assign beat_word    = data_mem[{req_index, beat}];

    always_comb begin
        merged_word = cur_word;
        for (int i = 0; i < LANES; i++) begin
            if (req_bval[i]) begin
                merged_word[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end
    end

    assign resp_word = req_wr ? merged_word : cur_word;

    // Outside RESP the last response word is held in rdata_q.
    assign CPU_ACK   = (state == RESP);
    assign CPU_RDATA = (state == RESP) ? resp_word : rdata_q;
    assign RAM_REQ   = (state == WRITEBACK) || (state == REFILL);
    assign RAM_RNW   = (state != WRITEBACK);
    assign RAM_WDATA = (state == WRITEBACK) ? beat_word : '0;

    always_comb begin
        RAM_ADDR = '0;
        case (state)
            WRITEBACK: RAM_ADDR = {victim_tag, req_index, beat, 2'b00};
            REFILL:    RAM_ADDR = {req_tag, req_index, beat, 2'b00};
            default:   RAM_ADDR = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            req_tag   <= '0;
            req_index <= '0;
            req_word  <= '0;
            req_wdata <= '0;
            req_bval  <= '0;
            req_wr    <= 1'b0;
            beat      <= '0;
            rdata_q   <= '0;
            valid     <= '0;
            dirty     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CPU_RD || CPU_WR) begin
                        req_tag   <= CPU_ADDR[ADDR_W-1 -: TAG_W];
                        req_index <= CPU_ADDR[OFFSET_W +: INDEX_W];
                        req_word  <= CPU_ADDR[2 +: WORD_W];
                        req_wdata <= CPU_WDATA;
                        req_bval  <= CPU_BVAL;
                        req_wr    <= CPU_WR && !CPU_RD;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    beat <= '0;
                    if (hit) begin
                        state <= RESP;
                    end else if (victim_dirty) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= REFILL;
                    end
                end
                WRITEBACK: begin
                    if (beat_done) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            dirty[req_index] <= 1'b0;
                            state            <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    // The line only becomes valid once every beat has landed.
                    if (beat_done) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            valid[req_index] <= 1'b1;
                            dirty[req_index] <= 1'b0;
                            state            <= RESP;
                        end
                    end
                end
                RESP: begin
                    rdata_q <= resp_word;
                    if (req_wr) begin
                        dirty[req_index] <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == REFILL && beat_done) begin
            data_mem[{req_index, beat}] <= RAM_RDATA;
            if (beat == LAST_BEAT) begin
                tag_mem[req_index] <= req_tag;
            end
        end
        if (state == RESP && req_wr) begin
            data_mem[{req_index, req_word}] <= merged_word;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HIT_CNT  <= '0;
            MISS_CNT <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (HIT_CNT != 16'hFFFF) HIT_CNT <= HIT_CNT + 16'd1;
            end else begin
                if (MISS_CNT != 16'hFFFF) MISS_CNT <= MISS_CNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_memory.sv
// tb/tb_cache_memory.sv - table-driven bench for cache_memory with a beat-logging RAM model
module tb_cache_memory;
    logic        CLK;
    logic        RESET;
    logic [13:0] CPU_ADDR;
    logic        CPU_RD;
    logic        CPU_WR;
    logic [31:0] CPU_WDATA;
    logic [3:0]  CPU_BVAL;
    logic [31:0] CPU_RDATA;
    logic        CPU_ACK;
    logic        RAM_REQ;
    logic        RAM_RNW;
    logic [13:0] RAM_ADDR;
    logic [31:0] RAM_WDATA;
    logic [31:0] RAM_RDATA;
    logic        RAM_ACK;
`ifdef CACHE_STATS_EN
    logic [15:0] HIT_CNT;
    logic [15:0] MISS_CNT;
`endif

    cache_memory dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_ADDR(CPU_ADDR), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR),
        .CPU_WDATA(CPU_WDATA), .CPU_BVAL(CPU_BVAL),
        .CPU_RDATA(CPU_RDATA), .CPU_ACK(CPU_ACK),
        .RAM_REQ(RAM_REQ), .RAM_RNW(RAM_RNW), .RAM_ADDR(RAM_ADDR),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA), .RAM_ACK(RAM_ACK)
`ifdef CACHE_STATS_EN
        , .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
`endif
    );

    typedef struct {
        logic             rd;
        logic             wr;
        logic [13:0]      addr;
        logic [31:0]      wdata;
        logic [3:0]       bval;
        logic             pat;
        logic             wt;
        logic [31:0]      exp_rdata;
        int               lat;
        int               n_wb;
        logic [13:0]      wb_base;
        logic [3:0][31:0] wbd;
        int               n_rd;
        logic [13:0]      rd_base;
    } vec_t;

    typedef struct {
        logic        rnw;
        logic [13:0] addr;
        logic [31:0] wdata;
    } beat_t;

    int    checks;
    int    errors;
    logic  ram_pat;
    logic  ack_wait;
    beat_t beats[$];
    vec_t  vecs[14];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM model: constant 1, or address-tagged data; optional ack every other cycle.
    assign RAM_RDATA = ram_pat ? (32'hA000_0000 | {18'd0, RAM_ADDR}) : 32'd1;

    always @(posedge CLK) begin
        #1;
        if (ack_wait) RAM_ACK = ~RAM_ACK;
        else          RAM_ACK = 1'b1;
    end

    always @(negedge CLK) begin
        if (RAM_REQ && RAM_ACK) beats.push_back('{RAM_RNW, RAM_ADDR, RAM_WDATA});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [13:0] addr,
                                input logic [31:0] wdata, input logic [3:0] bval,
                                input logic pat, input logic wt, input logic [31:0] exp_rdata,
                                input int lat, input int n_wb, input logic [13:0] wb_base,
                                input logic [3:0][31:0] wbd, input int n_rd,
                                input logic [13:0] rd_base);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.bval = bval;
        v.pat = pat; v.wt = wt; v.exp_rdata = exp_rdata; v.lat = lat;
        v.n_wb = n_wb; v.wb_base = wb_base; v.wbd = wbd;
        v.n_rd = n_rd; v.rd_base = rd_base;
        return v;
    endfunction

    task automatic do_req(input int idx, input vec_t v);
        int   cyc;
        logic got;
        beats.delete();
        ram_pat  = v.pat;
        ack_wait = v.wt;
        @(negedge CLK);
        CPU_RD = v.rd; CPU_WR = v.wr; CPU_ADDR = v.addr;
        CPU_WDATA = v.wdata; CPU_BVAL = v.bval;
        @(posedge CLK);
        #1;
        CPU_RD = 1'b0; CPU_WR = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (CPU_ACK) got = 1'b1;
        end
        chk($sformatf("v%0d ack_seen", idx), {31'd0, got}, 32'd1);
        if (got) begin
            chk($sformatf("v%0d rdata", idx), CPU_RDATA, v.exp_rdata);
            if (v.lat >= 0) chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
            @(negedge CLK);
            chk($sformatf("v%0d ack_pulse", idx), {31'd0, CPU_ACK}, 32'd0);
            chk($sformatf("v%0d rdata_hold", idx), CPU_RDATA, v.exp_rdata);
            chk($sformatf("v%0d beat_count", idx), 32'(beats.size()), 32'(v.n_wb + v.n_rd));
            if (beats.size() == v.n_wb + v.n_rd) begin
                for (int k = 0; k < v.n_wb; k++) begin
                    chk($sformatf("v%0d wb%0d rnw", idx, k), {31'd0, beats[k].rnw}, 32'd0);
                    chk($sformatf("v%0d wb%0d addr", idx, k), {18'd0, beats[k].addr},
                        {18'd0, v.wb_base + 14'(4 * k)});
                    chk($sformatf("v%0d wb%0d data", idx, k), beats[k].wdata, v.wbd[k]);
                end
                for (int k = 0; k < v.n_rd; k++) begin
                    chk($sformatf("v%0d rf%0d rnw", idx, k), {31'd0, beats[v.n_wb + k].rnw}, 32'd1);
                    chk($sformatf("v%0d rf%0d addr", idx, k), {18'd0, beats[v.n_wb + k].addr},
                        {18'd0, v.rd_base + 14'(4 * k)});
                end
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cpu_ack"},   {31'd0, CPU_ACK}, 32'd0);
        chk({tag, " cpu_rdata"}, CPU_RDATA, 32'd0);
        chk({tag, " ram_req"},   {31'd0, RAM_REQ}, 32'd0);
        chk({tag, " ram_rnw"},   {31'd0, RAM_RNW}, 32'd1);
        chk({tag, " ram_addr"},  {18'd0, RAM_ADDR}, 32'd0);
        chk({tag, " ram_wdata"}, RAM_WDATA, 32'd0);
    endtask

    initial begin
        logic hit_reset;
        checks = 0; errors = 0;
        ram_pat = 1'b0; ack_wait = 1'b0; RAM_ACK = 1'b1;
        CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0; CPU_BVAL = '0;

        vecs[0]  = mk(1, 0, 14'h0210, 32'h0, 4'h0, 0, 0, 32'h0000_0001, 6,  0, 14'h0, '0, 4, 14'h0210);
        vecs[1]  = mk(1, 0, 14'h0210, 32'h0, 4'h0, 0, 0, 32'h0000_0001, 2,  0, 14'h0, '0, 0, 14'h0);
        vecs[2]  = mk(0, 1, 14'h021C, 32'h1111_1111, 4'hF, 0, 0, 32'h1111_1111, 2, 0, 14'h0, '0, 0, 14'h0);
        vecs[3]  = mk(1, 0, 14'h021C, 32'h0, 4'h0, 0, 0, 32'h1111_1111, 2,  0, 14'h0, '0, 0, 14'h0);
        vecs[4]  = mk(0, 1, 14'h3F1C, 32'h1111_1111, 4'h3, 0, 0, 32'h0000_1111, 10, 4, 14'h0210,
                      {32'h1111_1111, 32'h1, 32'h1, 32'h1}, 4, 14'h3F10);
        vecs[5]  = mk(1, 0, 14'h3F1C, 32'h0, 4'h0, 0, 0, 32'h0000_1111, 2,  0, 14'h0, '0, 0, 14'h0);
        vecs[6]  = mk(0, 1, 14'h3F18, 32'hFFFF_FFFF, 4'h0, 0, 0, 32'h0000_0001, 2, 0, 14'h0, '0, 0, 14'h0);
        vecs[7]  = mk(1, 1, 14'h3F14, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0000_0001, 2, 0, 14'h0, '0, 0, 14'h0);
        vecs[8]  = mk(1, 0, 14'h3F14, 32'h0, 4'h0, 0, 0, 32'h0000_0001, 2,  0, 14'h0, '0, 0, 14'h0);
        vecs[9]  = mk(1, 0, 14'h0510, 32'h0, 4'h0, 1, 0, 32'hA000_0510, 10, 4, 14'h3F10,
                      {32'h0000_1111, 32'h1, 32'h1, 32'h1}, 4, 14'h0510);
        vecs[10] = mk(1, 0, 14'h051C, 32'h0, 4'h0, 1, 0, 32'hA000_051C, 2,  0, 14'h0, '0, 0, 14'h0);
        vecs[11] = mk(1, 0, 14'h0634, 32'h0, 4'h0, 1, 1, 32'hA000_0634, -1, 0, 14'h0, '0, 4, 14'h0630);
        vecs[12] = mk(1, 0, 14'h0120, 32'h0, 4'h0, 0, 0, 32'h0000_0001, 6,  0, 14'h0, '0, 4, 14'h0120);
        vecs[13] = mk(1, 0, 14'h0510, 32'h0, 4'h0, 1, 0, 32'hA000_0510, 6,  0, 14'h0, '0, 4, 14'h0510);

        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk_reset_outputs("por");
`ifdef CACHE_STATS_EN
        chk("por hit_cnt",  {16'd0, HIT_CNT},  32'd0);
        chk("por miss_cnt", {16'd0, MISS_CNT}, 32'd0);
`endif
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_req(i, vecs[i]);
`ifdef CACHE_STATS_EN
            if (i == 4) begin
                chk("stats hit_cnt",  {16'd0, HIT_CNT},  32'd3);
                chk("stats miss_cnt", {16'd0, MISS_CNT}, 32'd2);
            end
`endif
        end

        // Abort a refill of 0x120 while beat 2 is outstanding.
        ram_pat = 1'b0; ack_wait = 1'b0;
        @(negedge CLK);
        CPU_RD = 1'b1; CPU_ADDR = 14'h0120;
        @(posedge CLK);
        #1;
        CPU_RD = 1'b0;
        hit_reset = 1'b0;
        for (int c = 0; c < 20 && !hit_reset; c++) begin
            @(negedge CLK);
            if (RAM_REQ && RAM_ADDR == 14'h0128) hit_reset = 1'b1;
        end
        chk("mid refill beat2 reached", {31'd0, hit_reset}, 32'd1);
        RESET = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        repeat (2) @(negedge CLK);
        RESET = 1'b1;

        for (int i = 12; i < 14; i++) begin
            do_req(i, vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
